// File: rtl/stack_exec.sv
// Execute unit for the tinycpu operand stack. It accepts ops over valid/ready, guards depth,
// drives the stack's load/push/pop port, and runs a W-cycle shift-add multiply.
module stack_exec #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [3:0]                 opcode,
  input  logic [W-1:0]               imm,
  output logic                       stk_load,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [W-1:0]               stk_d,
  input  logic [W-1:0]               stk_qtop,
  input  logic [W-1:0]               stk_qnext,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_illegal
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int CW = $clog2(W);
  localparam logic [DW-1:0] FULL     = DW'(DEPTH);
  localparam logic [CW-1:0] LAST_ITR = CW'(W-1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_DUP   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_OUT   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT, S_WB} state_e;

  state_e         state_q, state_d;
  logic [3:0]     opcode_q, opcode_d;
  logic [W-1:0]   imm_q, imm_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mult_q, mult_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_unf_q, err_unf_d;
  logic           err_ill_q, err_ill_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    opcode_d    = opcode_q;
    imm_d       = imm_q;
    depth_d     = depth_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;
    err_ill_d   = err_ill_q;
    instr_ready = 1'b0;
    stk_load    = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_d       = '0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opcode_d = opcode;
          imm_d    = imm;
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        case (opcode_q)
          OP_NOP: ;
          OP_PUSHI, OP_DUP: begin
            if (depth_q == FULL) err_ovf_d = 1'b1;
            else begin
              stk_push = 1'b1;
              stk_load = (opcode_q == OP_PUSHI);
              stk_d    = (opcode_q == OP_PUSHI) ? imm_q : '0;
              depth_d  = depth_q + DW'(1);
            end
          end
          OP_POP: begin
            if (depth_q == '0) err_unf_d = 1'b1;
            else begin
              stk_pop = 1'b1;
              depth_d = depth_q - DW'(1);
            end
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            if (depth_q < DW'(2)) err_unf_d = 1'b1;
            else begin
              stk_load = 1'b1;
              stk_pop  = 1'b1;
              depth_d  = depth_q - DW'(1);
              case (opcode_q)
                OP_ADD:  stk_d = stk_qnext + stk_qtop;
                OP_SUB:  stk_d = stk_qnext - stk_qtop;
                OP_AND:  stk_d = stk_qnext & stk_qtop;
                OP_OR:   stk_d = stk_qnext | stk_qtop;
                default: stk_d = stk_qnext ^ stk_qtop;
              endcase
            end
          end
          OP_NOT: begin
            if (depth_q == '0) err_unf_d = 1'b1;
            else begin
              stk_load = 1'b1;
              stk_d    = ~stk_qtop;
            end
          end
          OP_MUL: begin
            // Operands are captured now; the stack is only written back from WB.
            if (depth_q < DW'(2)) err_unf_d = 1'b1;
            else begin
              mcand_d = stk_qnext;
              mult_d  = stk_qtop;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MULT;
            end
          end
          OP_OUT: begin
            if (depth_q == '0) err_unf_d = 1'b1;
            else begin
              out_valid_d = 1'b1;
              out_data_d  = stk_qtop;
              stk_pop     = 1'b1;
              depth_d     = depth_q - DW'(1);
            end
          end
          default: err_ill_d = 1'b1;
        endcase
      end

      S_MULT: begin
        if (mult_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITR) state_d = S_WB;
      end

      S_WB: begin
        stk_load = 1'b1;
        stk_pop  = 1'b1;
        stk_d    = acc_q;
        depth_d  = depth_q - DW'(1);
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      imm_q       <= '0;
      depth_q     <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      imm_q       <= imm_d;
      depth_q     <= depth_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_ill_q   <= err_ill_d;
    end
  end

  assign depth         = depth_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_illegal   = err_ill_q;

endmodule

// File: tb/tb_stack_exec.sv
// Self-checking bench for stack_exec: a register stack on the stk_* port, directed vector
// table, multi-cycle corner sequences, and random ops against a queue-based reference model.
module tb_stack_exec;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  imm;
  logic          stk_load, stk_push, stk_pop;
  logic [W-1:0]  stk_d;
  logic [W-1:0]  stk_qtop, stk_qnext;
  logic [3:0]    depth;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          err_overflow, err_underflow, err_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int stk_act  = 0;
  int pp_viol  = 0;

  logic [W-1:0] stk_mem [DEPTH];

  stack_exec #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .imm(imm), .stk_load(stk_load), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_d(stk_d), .stk_qtop(stk_qtop), .stk_qnext(stk_qnext), .depth(depth),
    .out_valid(out_valid), .out_data(out_data), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Operand stack driven by the DUT; load wins over pop on q0.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stk_mem[i] <= '0;
    end else begin
      if (stk_push) for (int i = 1; i < DEPTH; i++) stk_mem[i] <= stk_mem[i-1];
      if (stk_pop) begin
        for (int i = 0; i < DEPTH-1; i++) stk_mem[i] <= stk_mem[i+1];
        stk_mem[DEPTH-1] <= '0;
      end
      if (stk_load) stk_mem[0] <= stk_d;
    end
  end
  assign stk_qtop  = stk_mem[0];
  assign stk_qnext = stk_mem[1];

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) out_cnt++;
      if (stk_push && stk_pop) pp_viol++;
      if (stk_load || stk_push || stk_pop) stk_act++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one op and returns cycles from accept until instr_ready is seen again.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] data, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_before_issue", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    opcode      = op;
    imm         = data;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode      = '0;
    imm         = '0;
    lat = 1;
    while (!instr_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    #1;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] imm;
    logic [W-1:0] exp_top;
    int           exp_depth;
    int           exp_lat;
  } vec_t;

  vec_t vecs[24];
  logic [W-1:0] model[$];

  initial begin
    int lat, base, act0, exp_lat, exp_out_cnt, r;
    logic [3:0]   op;
    logic [W-1:0] data, a, b, exp_out_data, e;
    logic [31:0]  prod;
    logic         m_ovf, m_unf, m_ill;

    vecs = '{
      '{4'd1,  16'h0005, 16'h0005, 1, 2},  '{4'd1,  16'h0003, 16'h0003, 2, 2},
      '{4'd4,  16'h0000, 16'h0008, 1, 2},  '{4'd11, 16'h0000, 16'h0000, 0, 2},
      '{4'd1,  16'h0003, 16'h0003, 1, 2},  '{4'd1,  16'h0005, 16'h0005, 2, 2},
      '{4'd5,  16'h0000, 16'hFFFE, 1, 2},  '{4'd9,  16'h0000, 16'h0001, 1, 2},
      '{4'd2,  16'h0000, 16'h0000, 0, 2},  '{4'd1,  16'h0100, 16'h0100, 1, 2},
      '{4'd1,  16'h0101, 16'h0101, 2, 2},  '{4'd10, 16'h0000, 16'h0100, 1, W+3},
      '{4'd2,  16'h0000, 16'h0000, 0, 2},  '{4'd1,  16'hF0F0, 16'hF0F0, 1, 2},
      '{4'd1,  16'h3C3C, 16'h3C3C, 2, 2},  '{4'd6,  16'h0000, 16'h3030, 1, 2},
      '{4'd1,  16'h0F0F, 16'h0F0F, 2, 2},  '{4'd7,  16'h0000, 16'h3F3F, 1, 2},
      '{4'd1,  16'hFFFF, 16'hFFFF, 2, 2},  '{4'd8,  16'h0000, 16'hC0C0, 1, 2},
      '{4'd0,  16'h1234, 16'hC0C0, 1, 2},  '{4'd3,  16'h0000, 16'hC0C0, 2, 2},
      '{4'd4,  16'h0000, 16'h8180, 1, 2},  '{4'd2,  16'h0000, 16'h0000, 0, 2}
    };

    reset = 1'b0;
    instr_valid = 1'b0;
    opcode = '0;
    imm = '0;
    repeat (2) @(negedge clk);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_out", {15'd0, out_valid, out_data}, 32'd0);
    check("rst_err", {err_overflow, err_underflow, err_illegal}, 32'd0);
    check("rst_stk", {13'd0, stk_load, stk_push, stk_pop, stk_d}, 32'd0);
    reset = 1'b1;

    // Directed vector table: arithmetic, OUT, SUB/NOT, truncated MUL.
    base = out_cnt;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].imm, lat);
      check($sformatf("vec%0d_top", i), 32'(stk_qtop), 32'(vecs[i].exp_top));
      check($sformatf("vec%0d_depth", i), 32'(depth), 32'(vecs[i].exp_depth));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end
    check("vec_out_pulses", 32'(out_cnt - base), 32'd1);
    check("vec_out_data", 32'(out_data), 32'h0008);
    check("vec_no_err", {err_overflow, err_underflow, err_illegal}, 32'd0);

    // Overflow at full depth leaves contents intact.
    do_reset();
    for (int k = 1; k <= DEPTH; k++) issue(4'd1, 16'(k), lat);
    issue(4'd3, 16'h0000, lat);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    check("ovf_depth", 32'(depth), 32'(DEPTH));
    check("ovf_lat", 32'(lat), 32'd2);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("ovf_mem%0d", i), 32'(stk_mem[i]), 32'(DEPTH - i));

    // Underflow on a binary op with a single entry.
    do_reset();
    check("unf_cleared_ovf", 32'(err_overflow), 32'd0);
    issue(4'd1, 16'h0001, lat);
    issue(4'd4, 16'h0000, lat);
    check("unf_flag", 32'(err_underflow), 32'd1);
    check("unf_depth", 32'(depth), 32'd1);
    check("unf_top", 32'(stk_qtop), 32'd1);

    // Reset during the seventh MULT cycle aborts the multiply with no write-back.
    do_reset();
    issue(4'd1, 16'h0002, lat);
    issue(4'd1, 16'h0003, lat);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = 4'd10;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = '0;
    repeat (7) @(negedge clk);
    check("mul_busy", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_stk", {13'd0, stk_load, stk_push, stk_pop, stk_d}, 32'd0);
    check("abort_depth", 32'(depth), 32'd0);
    act0 = stk_act;
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_no_wb", 32'(stk_act - act0), 32'd0);
    check("abort_mem", {stk_mem[0], stk_mem[1]}, 32'd0);
    check("abort_depth_after", 32'(depth), 32'd0);

    // Reserved opcode: flag only, no stack activity, 2-cycle turnaround.
    do_reset();
    issue(4'd1, 16'h0007, lat);
    act0 = stk_act;
    issue(4'hE, 16'h0000, lat);
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_no_stk", 32'(stk_act - act0), 32'd0);
    check("ill_top", 32'(stk_qtop), 32'h0007);
    check("ill_depth", 32'(depth), 32'd1);

    // Random ops against a queue model (model[0] is the top of stack).
    do_reset();
    model.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_ill = 1'b0;
    exp_out_cnt  = out_cnt;
    exp_out_data = '0;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = 4'd1;
      else if (r < 40) op = 4'd3;
      else             op = 4'($urandom_range(0, 15));
      data = 16'($urandom);
      exp_lat = 2;
      case (op)
        4'd0: ;
        4'd1: if (model.size() == DEPTH) m_ovf = 1'b1; else model.push_front(data);
        4'd2: if (model.size() < 1) m_unf = 1'b1; else void'(model.pop_front());
        4'd3: begin
          if (model.size() == DEPTH) m_ovf = 1'b1;
          else model.push_front(model.size() > 0 ? model[0] : 16'h0000);
        end
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10: begin
          if (model.size() < 2) m_unf = 1'b1;
          else begin
            b = model.pop_front();
            a = model.pop_front();
            prod = 32'(a) * 32'(b);
            case (op)
              4'd4:    model.push_front(a + b);
              4'd5:    model.push_front(a - b);
              4'd6:    model.push_front(a & b);
              4'd7:    model.push_front(a | b);
              4'd8:    model.push_front(a ^ b);
              default: begin model.push_front(prod[15:0]); exp_lat = W + 3; end
            endcase
          end
        end
        4'd9: if (model.size() < 1) m_unf = 1'b1; else model[0] = ~model[0];
        4'd11: begin
          if (model.size() < 1) m_unf = 1'b1;
          else begin
            exp_out_data = model.pop_front();
            exp_out_cnt++;
          end
        end
        default: m_ill = 1'b1;
      endcase
      issue(op, data, lat);
      check($sformatf("rnd%0d_op%0d_lat", t, op), 32'(lat), 32'(exp_lat));
      check($sformatf("rnd%0d_depth", t), 32'(depth), 32'(model.size()));
      for (int i = 0; i < DEPTH; i++) begin
        e = (i < model.size()) ? model[i] : 16'h0000;
        check($sformatf("rnd%0d_mem%0d", t, i), 32'(stk_mem[i]), 32'(e));
      end
      check($sformatf("rnd%0d_err", t), {err_overflow, err_underflow, err_illegal},
            {29'd0, m_ovf, m_unf, m_ill});
      check($sformatf("rnd%0d_out_cnt", t), 32'(out_cnt), 32'(exp_out_cnt));
      check($sformatf("rnd%0d_out_data", t), 32'(out_data), 32'(exp_out_data));
    end

    check("push_pop_exclusive", 32'(pp_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
